axis_master: RTL

//  Transmit-side counterpart of the AXI-Stream slave bridge. Accepts 32-bit beats from a backend

---
 rtl/axis_master_if.sv | 32 +++
 rtl/axis_master.sv | 93 +++++++++
 2 files changed

// File: rtl/axis_master_if.sv
// Backend valid/ready beat source plus AXI4-Stream master lanes. The DUT takes the
// master side; a testbench or backend model takes the slave side.
interface axis_master_if;
    logic [31:0] bk_data;
    logic [3:0]  bk_tstrb;
    logic [3:0]  bk_tkeep;
    logic [1:0]  bk_user;
    logic        bk_tlast;
    logic        bk_valid;
    logic        bk_ready;
    logic        axis_tvalid;
    logic [31:0] axis_tdata;
    logic [3:0]  axis_tstrb;
    logic [3:0]  axis_tkeep;
    logic [1:0]  axis_tuser;
    logic        axis_tlast;
    logic        axis_tready;

    modport master (
        input  bk_data, bk_tstrb, bk_tkeep, bk_user, bk_tlast, bk_valid,
        output bk_ready,
        output axis_tvalid, axis_tdata, axis_tstrb, axis_tkeep, axis_tuser, axis_tlast,
        input  axis_tready
    );

    modport slave (
        output bk_data, bk_tstrb, bk_tkeep, bk_user, bk_tlast, bk_valid,
        input  bk_ready,
        input  axis_tvalid, axis_tdata, axis_tstrb, axis_tkeep, axis_tuser, axis_tlast,
        output axis_tready
    );
endinterface

// File: rtl/axis_master.sv
// AXI4-Stream transmit bridge: small register FIFO between a valid/ready backend and
// an AXIS master port, plus a packet-in-flight flag driven by the popped tlast.
module axis_master #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          axi_aclk,
    input  logic          axi_aresetn,
    axis_master_if.master bus,
    output logic [AW:0]   fifo_count,
    output logic          pkt_active
);
    typedef struct packed {
        logic        tlast;
        logic [1:0]  user;
        logic [3:0]  keep;
        logic [3:0]  strb;
        logic [31:0] data;
    } beat_t;

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    beat_t           r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    beat_t           w_in;
    beat_t           w_out;

    // Flags come only from r_count, so bk_ready has no path from axis_tready.
    assign w_full  = (r_count == CNT_FULL);
    assign w_empty = (r_count == '0);
    assign w_push  = bus.bk_valid & ~w_full;
    assign w_pop   = bus.axis_tready & ~w_empty;

    assign w_in = '{tlast: bus.bk_tlast, user: bus.bk_user, keep: bus.bk_tkeep,
                    strb: bus.bk_tstrb, data: bus.bk_data};

    // Storage needs no reset: the payload is only qualified by axis_tvalid.
    always_ff @(posedge axi_aclk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_in;
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) r_state <= S_IDLE;
        else              r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_pop && !w_out.tlast) w_state_nxt = S_ACTIVE;
            S_ACTIVE: if (w_pop &&  w_out.tlast) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    assign w_out = r_mem[r_rd_ptr];

    assign bus.bk_ready    = ~w_full;
    assign bus.axis_tvalid = ~w_empty;
    assign bus.axis_tdata  = w_out.data;
    assign bus.axis_tstrb  = w_out.strb;
    assign bus.axis_tkeep  = w_out.keep;
    assign bus.axis_tuser  = w_out.user;
    assign bus.axis_tlast  = w_out.tlast;
    assign fifo_count      = r_count;
    assign pkt_active      = (r_state == S_ACTIVE);
endmodule
